// File: rtl/instr_mem_loader_pkg.sv
// Shared constants, state encoding and helpers for the instruction-memory loader.
// Image length checks live here so the bench and the loader agree on the legal range.
package instr_mem_pkg;

  localparam int unsigned IMEM_DEPTH     = 135;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // A load is legal only if it is non-empty and fits in the memory.
  function automatic logic count_ok(input int unsigned n, input int unsigned depth);
    return (n != 0) && (n <= depth);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host/boot byte stream, load control/status and instruction-memory write port.
// master = host side driving the stream, slave = the loader.
interface instr_mem_loader_if #(
  parameter int unsigned CNT_W = 8
);
  import instr_mem_pkg::*;

  logic                  start;
  logic [CNT_W-1:0]      num_words;
  logic                  abort;
  logic                  byte_valid;
  logic [BYTE_W-1:0]     byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [INSTR_W-1:0]    mem_addr;
  logic [INSTR_W-1:0]    mem_wdata;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, num_words, abort, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
  );

  modport slave (
    input  start, num_words, abort, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
  );

endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// Shifts stream bytes MSB-first into a 32-bit word and counts bytes within the word.
// Clear resets only the byte counter; the shift register is overwritten by the next word.
module byte_assembler
  import instr_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [BYTE_W-1:0]  i_byte,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_word_full
);

  logic [INSTR_W-1:0] r_shreg;
  logic [BIDX_W-1:0]  r_byte_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg    <= '0;
      r_byte_idx <= '0;
    end else if (i_clear) begin
      r_byte_idx <= '0;
    end else if (i_load) begin
      r_shreg    <= {r_shreg[INSTR_W-BYTE_W-1:0], i_byte};
      r_byte_idx <= r_byte_idx + BIDX_W'(1);
    end
  end

  assign o_word      = r_shreg;
  assign o_word_full = (r_byte_idx == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a big-endian byte stream into instruction memory words 0..num_words-1,
// holding the CPU off for the whole load.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  instr_mem_loader_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_word_idx;
  logic [CNT_W-1:0]   r_count;
  logic               r_error;
  logic [INSTR_W-1:0] r_addr_hold;
  logic [INSTR_W-1:0] r_wdata_hold;

  logic [INSTR_W-1:0] w_shreg;
  logic [INSTR_W-1:0] w_wr_addr;
  logic               w_word_full;
  logic               w_start_ok;
  logic               w_accept;
  logic               w_reject;
  logic               w_abort;
  logic               w_load;
  logic               w_clear;
  logic               w_last;

  assign w_start_ok = count_ok(32'(bus.num_words), DEPTH);
  assign w_accept   = (r_state == ST_IDLE) && bus.start && w_start_ok;
  assign w_reject   = (r_state == ST_IDLE) && bus.start && !w_start_ok;
  assign w_abort    = ((r_state == ST_COLLECT) || (r_state == ST_WRITE)) && bus.abort;
  // Abort wins over a byte offered in the same cycle.
  assign w_load     = (r_state == ST_COLLECT) && bus.byte_valid && !bus.abort;
  assign w_clear    = w_accept || (r_state == ST_WRITE);
  assign w_last     = (r_word_idx == (r_count - CNT_W'(1)));
  assign w_wr_addr  = {{(INSTR_W-CNT_W){1'b0}}, r_word_idx};

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_byte     (bus.byte_data),
    .o_word     (w_shreg),
    .o_word_full(w_word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.done       = 1'b0;
    bus.busy       = (r_state != ST_IDLE);
    bus.cpu_hold   = (r_state != ST_IDLE);
    bus.error      = r_error;
    bus.mem_addr   = r_addr_hold;
    bus.mem_wdata  = r_wdata_hold;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        bus.byte_ready = 1'b1;
        if (bus.abort)                 w_next = ST_IDLE;
        else if (w_load && w_word_full) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        // The write presented this cycle completes even under abort.
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_wr_addr;
        bus.mem_wdata = w_shreg;
        if (bus.abort)   w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
        else             w_next = ST_COLLECT;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_idx   <= '0;
      r_count      <= '0;
      r_error      <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_error <= w_reject || w_abort;
      if (w_accept) begin
        r_count    <= bus.num_words;
        r_word_idx <= '0;
      end else if (r_state == ST_WRITE) begin
        r_word_idx <= r_word_idx + CNT_W'(1);
      end
      if (r_state == ST_WRITE) begin
        r_addr_hold  <= w_wr_addr;
        r_wdata_hold <= w_shreg;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: scoreboarded memory writes,
// a table of start-request vectors and hand-written multi-cycle sequences.
module tb_instr_mem_loader;
  import instr_mem_pkg::*;

  localparam int unsigned CNT_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instr_mem_loader_if #(.CNT_W(CNT_W)) bus ();

  instr_mem_loader #(.DEPTH(IMEM_DEPTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int   nw;
    logic exp_busy;
  } start_vec_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc_n    = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;
  int  hold_cnt = 0;
  int  busy_cnt = 0;
  int  done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin : mon
    wr_t e;
    if (!reset) begin
      if (bus.mem_we) begin
        wr_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_data", bus.mem_wdata, e.data);
        end
        check("ready_in_write", 32'(bus.byte_ready), 32'd0);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
      if (bus.error)    err_cnt++;
      if (bus.cpu_hold) hold_cnt++;
      if (bus.busy)     busy_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int nw);
    bus.start     = 1'b1;
    bus.num_words = CNT_W'(nw);
    cyc();
    bus.start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int k;
    if (gaps) repeat ($urandom_range(0, 2)) cyc();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    k = 0;
    while (!bus.byte_ready && k < 50) begin
      cyc();
      k++;
    end
    if (k >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: got byte_ready=0 expected 1 within 50 cycles");
    end else begin
      cyc();
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input bit gaps);
    wr_t w;
    w.addr = addr;
    w.data = data;
    sb_q.push_back(w);
    for (int i = 0; i < 4; i++) send_byte(data[31-8*i -: 8], gaps);
  endtask

  task automatic wait_done(input int base, input string name);
    int k;
    k = 0;
    while (done_cnt == base && k < 60) begin
      cyc();
      k++;
    end
    check(name, 32'(done_cnt > base), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    check({tag, "_cpu_hold"},   32'(bus.cpu_hold),   32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_done"},       32'(bus.done),       32'd0);
    check({tag, "_error"},      32'(bus.error),      32'd0);
    check({tag, "_mem_addr"},   bus.mem_addr,        32'd0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    start_vec_t tv[5];
    int b_err, b_done, b_wr, c0;
    logic [31:0] wd;

    tv[0] = '{nw: 0,   exp_busy: 1'b0};
    tv[1] = '{nw: 136, exp_busy: 1'b0};
    tv[2] = '{nw: 255, exp_busy: 1'b0};
    tv[3] = '{nw: 1,   exp_busy: 1'b1};
    tv[4] = '{nw: 135, exp_busy: 1'b1};

    bus.start = 1'b0; bus.num_words = '0; bus.abort = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;

    #3;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc();

    // Back-to-back 2-word load: data, latency and hold window.
    b_done = done_cnt;
    hold_cnt = 0;
    busy_cnt = 0;
    c0 = cyc_n;
    start_load(2);
    send_word(32'd0, 32'h2008_0005, 1'b0);
    send_word(32'd1, 32'h8C09_0004, 1'b0);
    wait_done(b_done, "two_word_done");
    repeat (3) cyc();
    check("two_word_done_once", 32'(done_cnt - b_done), 32'd1);
    check("two_word_latency",   32'(done_cyc - c0),     32'd11);
    check("two_word_hold_cyc",  32'(hold_cnt),          32'd11);
    check("two_word_busy_cyc",  32'(busy_cnt),          32'd11);
    check("hold_after_done",    32'(bus.cpu_hold),      32'd0);
    check("addr_held",          bus.mem_addr,           32'd1);
    check("wdata_held",         bus.mem_wdata,          32'h8C09_0004);

    // Asynchronous reset after two bytes, then a clean 1-word load.
    start_load(1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #1 reset = 1'b1;
    #1 check_idle_outputs("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    cyc();
    b_done = done_cnt;
    start_load(1);
    send_word(32'd0, 32'hDEAD_BEEF, 1'b0);
    wait_done(b_done, "after_reset_done");
    repeat (2) cyc();

    // 3-word load with random gaps on byte_valid.
    b_done = done_cnt;
    b_wr = wr_cnt;
    start_load(3);
    send_word(32'd0, 32'h0102_0304, 1'b1);
    send_word(32'd1, 32'hCAFE_F00D, 1'b1);
    send_word(32'd2, 32'h1357_9BDF, 1'b1);
    wait_done(b_done, "gap_load_done");
    repeat (2) cyc();
    check("gap_load_writes", 32'(wr_cnt - b_wr), 32'd3);
    check("gap_load_q_empty", 32'(sb_q.size()), 32'd0);

    // Start-request table: rejected lengths pulse error; accepted ones are aborted.
    for (int i = 0; i < 5; i++) begin
      b_err = err_cnt;
      b_wr = wr_cnt;
      start_load(tv[i].nw);
      cyc();
      check($sformatf("tv%0d_busy", i),     32'(bus.busy),     32'(tv[i].exp_busy));
      check($sformatf("tv%0d_cpu_hold", i), 32'(bus.cpu_hold), 32'(tv[i].exp_busy));
      repeat (2) cyc();
      check($sformatf("tv%0d_err", i), 32'(err_cnt - b_err), tv[i].exp_busy ? 32'd0 : 32'd1);
      if (tv[i].exp_busy) begin
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        repeat (2) cyc();
        check($sformatf("tv%0d_abort_err", i), 32'(err_cnt - b_err), 32'd1);
        check($sformatf("tv%0d_abort_idle", i), 32'(bus.busy), 32'd0);
      end
      check($sformatf("tv%0d_no_write", i), 32'(wr_cnt - b_wr), 32'd0);
    end

    // Abort after 5 bytes of a 2-word load, then a normal load.
    b_err = err_cnt;
    b_done = done_cnt;
    b_wr = wr_cnt;
    start_load(2);
    send_word(32'd0, 32'hA1B2_C3D4, 1'b0);
    send_byte(8'h77, 1'b0);
    bus.abort = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h88;
    cyc();
    bus.abort = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (3) cyc();
    check("abort_writes",  32'(wr_cnt - b_wr),     32'd1);
    check("abort_err",     32'(err_cnt - b_err),   32'd1);
    check("abort_no_done", 32'(done_cnt - b_done), 32'd0);
    check("abort_idle",    32'(bus.busy),          32'd0);
    b_done = done_cnt;
    start_load(1);
    send_word(32'd0, 32'h5566_7788, 1'b0);
    wait_done(b_done, "post_abort_done");
    repeat (2) cyc();

    // Full-depth load: last write lands at DEPTH-1.
    b_done = done_cnt;
    b_wr = wr_cnt;
    start_load(IMEM_DEPTH);
    for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
      wd = {8'(i), 8'(~i), 8'hA5, 8'(i * 3)};
      send_word(32'(i), wd, 1'b0);
    end
    wait_done(b_done, "full_done");
    repeat (3) cyc();
    check("full_writes",    32'(wr_cnt - b_wr),     32'(IMEM_DEPTH));
    check("full_done_once", 32'(done_cnt - b_done), 32'd1);
    check("full_last_addr", bus.mem_addr,           32'(IMEM_DEPTH - 1));
    check("full_q_empty",   32'(sb_q.size()),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
